// File: rtl/simon_seq_mem.sv
// simon_seq_mem: append-only symbol store; replays over valid/ready and checks guesses in order.
// Latency: replay 2 cycles/symbol, guess result pulses 1 cycle after acceptance.
// Backpressure: play_data held until play_ready; guesses ignored while guess_ready low. SIMON_SEQ_RAND_EN stores LFSR symbols.
module simon_seq_mem #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             append_valid,
  input  logic [WIDTH-1:0] append_data,
  output logic             append_ready,
  input  logic             play_start,
  output logic             play_valid,
  output logic [WIDTH-1:0] play_data,
  output logic             play_last,
  input  logic             play_ready,
  input  logic             check_start,
  input  logic             guess_valid,
  input  logic [WIDTH-1:0] guess_data,
  output logic             guess_ready,
  output logic             check_match,
  output logic             check_fail,
  output logic             check_done,
`ifdef SIMON_SEQ_RAND_EN
  output logic [WIDTH-1:0] rand_sym,
`endif
  output logic [LEN_W-1:0] seq_len,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, PLAY_RD, PLAY_OUT, CHK_RD, CHK_WAIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [LEN_W-1:0] index;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] wr_sym;
  logic             start_ok;
  logic             append_fire;
  logic             is_last;

  assign full         = (seq_len == LEN_W'(DEPTH));
  assign empty        = (seq_len == '0);
  assign busy         = (state != IDLE);
  assign start_ok     = (play_start || check_start) && !empty;
  // A start in the same cycle wins over an append, so the append is refused.
  assign append_ready = (state == IDLE) && !full && !start_ok && !clear && !reset;
  assign append_fire  = append_valid && append_ready;
  assign is_last      = (index == seq_len - LEN_W'(1));

  assign play_valid  = (state == PLAY_OUT);
  assign play_last   = (state == PLAY_OUT) && is_last;
  assign play_data   = rd_data;
  assign guess_ready = (state == CHK_WAIT);

`ifdef SIMON_SEQ_RAND_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset)
      lfsr <= 16'hACE1;
    else
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  assign rand_sym = lfsr[WIDTH-1:0];
  assign wr_sym   = rand_sym;
`else
  assign wr_sym = append_data;
`endif

  always_ff @(posedge clock) begin
    if (append_fire)
      mem[seq_len[ADDR_W-1:0]] <= wr_sym;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      seq_len     <= '0;
      index       <= '0;
      rd_data     <= '0;
      check_match <= 1'b0;
      check_fail  <= 1'b0;
      check_done  <= 1'b0;
    end else begin
      check_match <= 1'b0;
      check_fail  <= 1'b0;
      check_done  <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        seq_len <= '0;
        index   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              index <= '0;
              state <= play_start ? PLAY_RD : CHK_RD;
            end else if (append_fire) begin
              seq_len <= seq_len + LEN_W'(1);
            end
          end
          PLAY_RD: begin
            rd_data <= mem[index[ADDR_W-1:0]];
            state   <= PLAY_OUT;
          end
          PLAY_OUT: begin
            if (play_ready) begin
              if (is_last) begin
                state <= IDLE;
              end else begin
                index <= index + LEN_W'(1);
                state <= PLAY_RD;
              end
            end
          end
          CHK_RD: begin
            rd_data <= mem[index[ADDR_W-1:0]];
            state   <= CHK_WAIT;
          end
          CHK_WAIT: begin
            if (guess_valid) begin
              if (guess_data != rd_data) begin
                check_fail <= 1'b1;
                state      <= IDLE;
              end else if (is_last) begin
                check_done <= 1'b1;
                state      <= IDLE;
              end else begin
                check_match <= 1'b1;
                index       <= index + LEN_W'(1);
                state       <= CHK_RD;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_seq_mem.sv
// Bench for simon_seq_mem: queue-based reference model of the stored sequence, randomized symbols/backpressure/guesses.
module tb_simon_seq_mem;
  localparam int WIDTH = 2;
  localparam int DEPTH = 16;
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset, clear, append_valid, play_start, play_ready, check_start, guess_valid;
  logic [WIDTH-1:0] append_data, guess_data, play_data;
  logic             append_ready, play_valid, play_last, guess_ready;
  logic             check_match, check_fail, check_done, full, empty, busy;
  logic [LEN_W-1:0] seq_len;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] obs_data[$];
  bit               obs_last[$];
  logic [2:0]       obs_res[$];
  bit               obs_to;
  int               obs_unstable;
  int               overlap_cnt = 0;
  int               multi_cnt = 0;
  int               pulse_cnt = 0;

  always #5 clock = ~clock;

  simon_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .append_valid(append_valid), .append_data(append_data), .append_ready(append_ready),
    .play_start(play_start), .play_valid(play_valid), .play_data(play_data),
    .play_last(play_last), .play_ready(play_ready),
    .check_start(check_start), .guess_valid(guess_valid), .guess_data(guess_data),
    .guess_ready(guess_ready), .check_match(check_match), .check_fail(check_fail),
    .check_done(check_done), .seq_len(seq_len), .full(full), .empty(empty), .busy(busy)
  );

  always @(negedge clock) begin
    if (play_valid && guess_ready) overlap_cnt++;
    if ((int'(check_match) + int'(check_fail) + int'(check_done)) > 1) multi_cnt++;
    if (check_match || check_fail || check_done) pulse_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_append(input logic [WIDTH-1:0] sym, output bit acc);
    append_valid = 1'b1;
    append_data  = sym;
    @(negedge clock);
    acc = append_ready;
    step();
    append_valid = 1'b0;
    if (acc) model.push_back(sym);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    model.delete();
  endtask

  // Collects the replayed stream; records any change of a stalled symbol.
  task automatic play_run(input bit do_start, input int max_stall);
    logic [WIDTH-1:0] hd;
    bit hv, done;
    int guard;
    obs_data.delete(); obs_last.delete();
    obs_unstable = 0; hv = 0; done = 0; guard = 0; hd = '0;
    if (do_start) begin
      play_start = 1'b1;
      step();
      play_start = 1'b0;
    end
    while (!done && guard < 500) begin
      play_ready = ($urandom_range(0, max_stall) == 0);
      @(negedge clock);
      if (hv && (!play_valid || play_data !== hd)) obs_unstable++;
      hv = 0;
      if (play_valid && play_ready) begin
        obs_data.push_back(play_data);
        obs_last.push_back(play_last);
        if (play_last) done = 1;
      end else if (play_valid) begin
        hv = 1;
        hd = play_data;
      end
      step();
      guard++;
    end
    play_ready = 1'b0;
    obs_to = !done;
  endtask

  // Presents guesses in order (guess held through CHK_RD) and records each result pulse triple {done,fail,match}.
  task automatic check_run(input logic [WIDTH-1:0] g[$]);
    int i, guard;
    bit fin, acc;
    obs_res.delete();
    i = 0; fin = 0; guard = 0;
    check_start = 1'b1;
    step();
    check_start = 1'b0;
    while (!fin && guard < 500 && i < g.size()) begin
      guess_valid = 1'b1;
      guess_data  = g[i];
      @(negedge clock);
      acc = guess_ready;
      step();
      guard++;
      if (acc) begin
        @(negedge clock);
        obs_res.push_back({check_done, check_fail, check_match});
        if (check_fail || check_done) fin = 1;
        i++;
      end
    end
    guess_valid = 1'b0;
    obs_to = !fin;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (seq_len !== '0) begin errors++; $display("FAIL reset_seq_len: got %0d expected 0", seq_len); end
    checks++;
    if ({empty, full, busy} !== 3'b100) begin errors++; $display("FAIL reset_flags: got empty/full/busy=%b expected 100", {empty, full, busy}); end
    checks++;
    if ({play_valid, play_last, guess_ready, check_match, check_fail, check_done} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000", {play_valid, play_last, guess_ready, check_match, check_fail, check_done});
    end
    step();
  endtask

  task automatic test_play();
    bit acc;
    logic [WIDTH-1:0] syms[3];
    syms[0] = 2'd3; syms[1] = 2'd1; syms[2] = 2'd2;
    do_clear();
    for (int k = 0; k < 3; k++) begin
      do_append(syms[k], acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL play_append_ready: got %0b expected 1", acc); end
    end
    @(negedge clock);
    checks++;
    if ({seq_len, empty, full} !== {LEN_W'(3), 2'b00}) begin
      errors++; $display("FAIL play_len: got len=%0d empty=%0b full=%0b expected 3 0 0", seq_len, empty, full);
    end
    step();
    play_run(1'b1, 0);
    checks++;
    if (obs_to || obs_data.size() != 3) begin
      errors++; $display("FAIL play_count: got %0d symbols timeout=%0b expected 3", obs_data.size(), obs_to);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_data[k] !== syms[k] || obs_last[k] !== (k == 2)) begin
          errors++; $display("FAIL play_sym%0d: got data=%0d last=%0b expected %0d %0b", k, obs_data[k], obs_last[k], syms[k], k == 2);
        end
      end
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL play_busy_end: got %0b expected 0", busy); end
    step();
  endtask

  task automatic test_full();
    bit acc;
    do_clear();
    for (int k = 0; k < DEPTH; k++) do_append(WIDTH'($urandom), acc);
    @(negedge clock);
    checks++;
    if ({full, append_ready, seq_len} !== {2'b10, LEN_W'(DEPTH)}) begin
      errors++; $display("FAIL full_flags: got full=%0b ready=%0b len=%0d expected 1 0 %0d", full, append_ready, seq_len, DEPTH);
    end
    step();
    do_append(WIDTH'($urandom), acc);
    @(negedge clock);
    checks++;
    if (acc !== 1'b0 || seq_len !== LEN_W'(DEPTH)) begin
      errors++; $display("FAIL full_overflow: got acc=%0b len=%0d expected 0 %0d", acc, seq_len, DEPTH);
    end
    step();
    play_run(1'b1, 3);
    checks++;
    if (obs_to || obs_data.size() != model.size() || obs_unstable != 0) begin
      errors++; $display("FAIL full_replay: got %0d symbols unstable=%0d expected %0d 0", obs_data.size(), obs_unstable, model.size());
    end else begin
      for (int k = 0; k < model.size(); k++) begin
        checks++;
        if (obs_data[k] !== model[k]) begin errors++; $display("FAIL full_sym%0d: got %0d expected %0d", k, obs_data[k], model[k]); end
      end
    end
  endtask

  task automatic test_check();
    bit acc;
    logic [WIDTH-1:0] g[$];
    do_clear();
    do_append(2'd0, acc);
    do_append(2'd2, acc);
    g.push_back(2'd0); g.push_back(2'd2);
    check_run(g);
    checks++;
    if (obs_to || obs_res.size() != 2 || obs_res[0] !== 3'b001 || obs_res[1] !== 3'b100) begin
      errors++; $display("FAIL check_pass: got n=%0d res0=%b res1=%b expected 001 100", obs_res.size(), obs_res[0], obs_res[1]);
    end
    g.delete();
    g.push_back(2'd0); g.push_back(2'd3);
    check_run(g);
    checks++;
    if (obs_to || obs_res.size() != 2 || obs_res[0] !== 3'b001 || obs_res[1] !== 3'b010) begin
      errors++; $display("FAIL check_wrong: got n=%0d res0=%b res1=%b expected 001 010", obs_res.size(), obs_res[0], obs_res[1]);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || seq_len !== LEN_W'(2)) begin errors++; $display("FAIL check_idle: got busy=%0b len=%0d expected 0 2", busy, seq_len); end
    step();
  endtask

  task automatic test_backpressure();
    bit acc, seen;
    int guard;
    do_clear();
    for (int k = 0; k < 3; k++) do_append(WIDTH'($urandom), acc);
    play_ready = 1'b0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    seen = 0; guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clock);
      if (play_valid) seen = 1; else step();
      guard++;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_valid: got no play_valid expected valid within 20 cycles"); end
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (play_valid !== 1'b1 || play_data !== model[0]) begin
        errors++; $display("FAIL bp_hold%0d: got valid=%0b data=%0d expected 1 %0d", c, play_valid, play_data, model[0]);
      end
      step();
    end
    play_ready = 1'b1;
    step();
    play_run(1'b0, 0);
    checks++;
    if (obs_to || obs_data.size() != 2 || obs_data[0] !== model[1] || obs_data[1] !== model[2]) begin
      errors++; $display("FAIL bp_rest: got n=%0d d0=%0d d1=%0d expected 2 %0d %0d", obs_data.size(), obs_data[0], obs_data[1], model[1], model[2]);
    end
  endtask

  task automatic test_clear();
    bit acc, seen;
    int guard, p0;
    do_clear();
    for (int k = 0; k < 4; k++) do_append(WIDTH'($urandom), acc);
    play_ready = 1'b0;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    seen = 0; guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clock);
      if (play_valid) seen = 1; else step();
      guard++;
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    model.delete();
    @(negedge clock);
    checks++;
    if ({busy, empty, play_valid, seq_len} !== {3'b010, LEN_W'(0)} || !seen) begin
      errors++; $display("FAIL clear_play: got busy=%0b empty=%0b valid=%0b len=%0d seen=%0b expected 0 1 0 0 1", busy, empty, play_valid, seq_len, seen);
    end
    step();
    do_append(WIDTH'($urandom), acc);
    do_append(WIDTH'($urandom), acc);
    p0 = pulse_cnt;
    check_start = 1'b1;
    step();
    check_start = 1'b0;
    seen = 0; guard = 0;
    while (!seen && guard < 20) begin
      @(negedge clock);
      if (guess_ready) seen = 1; else step();
      guard++;
    end
    guess_valid = 1'b1;
    guess_data  = model[0];
    clear = 1'b1;
    step();
    clear = 1'b0;
    guess_valid = 1'b0;
    model.delete();
    repeat (3) step();
    @(negedge clock);
    checks++;
    if (pulse_cnt != p0 || busy !== 1'b0 || seq_len !== '0 || !seen) begin
      errors++; $display("FAIL clear_check: got pulses=%0d busy=%0b len=%0d seen=%0b expected 0 0 0 1", pulse_cnt - p0, busy, seq_len, seen);
    end
    step();
    play_start = 1'b1;
    check_start = 1'b1;
    step();
    play_start = 1'b0;
    check_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL empty_start%0d: got busy=%0b expected 0", c, busy); end
      step();
    end
  endtask

  task automatic test_priority();
    bit acc;
    do_clear();
    do_append(WIDTH'($urandom), acc);
    do_append(WIDTH'($urandom), acc);
    play_start = 1'b1;
    check_start = 1'b1;
    append_valid = 1'b1;
    append_data = WIDTH'($urandom);
    @(negedge clock);
    checks++;
    if (append_ready !== 1'b0) begin errors++; $display("FAIL prio_append_ready: got %0b expected 0", append_ready); end
    step();
    play_start = 1'b0;
    check_start = 1'b0;
    append_valid = 1'b0;
    play_run(1'b0, 1);
    checks++;
    if (obs_to || obs_data.size() != 2 || obs_data[0] !== model[0] || obs_data[1] !== model[1]) begin
      errors++; $display("FAIL prio_replay: got n=%0d timeout=%0b expected 2 symbols", obs_data.size(), obs_to);
    end
    @(negedge clock);
    checks++;
    if (seq_len !== LEN_W'(2)) begin errors++; $display("FAIL prio_len: got %0d expected 2", seq_len); end
    step();
  endtask

  task automatic test_random();
    bit acc;
    int n;
    logic [WIDTH-1:0] g[$];
    logic [2:0] exp_res[$];
    for (int r = 0; r < 8; r++) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) do_append(WIDTH'($urandom), acc);
      play_run(1'b1, $urandom_range(0, 3));
      checks++;
      if (obs_to || obs_data.size() != n || obs_unstable != 0) begin
        errors++; $display("FAIL rand%0d_replay_len: got %0d unstable=%0d expected %0d 0", r, obs_data.size(), obs_unstable, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (obs_data[k] !== model[k] || obs_last[k] !== (k == n - 1)) begin
            errors++; $display("FAIL rand%0d_sym%0d: got %0d/%0b expected %0d/%0b", r, k, obs_data[k], obs_last[k], model[k], k == n - 1);
          end
        end
      end
      g.delete();
      exp_res.delete();
      for (int k = 0; k < n; k++)
        g.push_back(($urandom_range(0, 5) == 0) ? model[k] + WIDTH'(1) : model[k]);
      for (int k = 0; k < n; k++) begin
        if (g[k] !== model[k]) begin exp_res.push_back(3'b010); break; end
        exp_res.push_back((k == n - 1) ? 3'b100 : 3'b001);
      end
      check_run(g);
      checks++;
      if (obs_to || obs_res.size() != exp_res.size()) begin
        errors++; $display("FAIL rand%0d_check_len: got %0d results expected %0d", r, obs_res.size(), exp_res.size());
      end else begin
        for (int k = 0; k < exp_res.size(); k++) begin
          checks++;
          if (obs_res[k] !== exp_res[k]) begin errors++; $display("FAIL rand%0d_res%0d: got %b expected %b", r, k, obs_res[k], exp_res[k]); end
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL overlap: got %0d cycles with play_valid&guess_ready expected 0", overlap_cnt); end
    checks++;
    if (multi_cnt != 0) begin errors++; $display("FAIL pulse_exclusive: got %0d multi-pulse cycles expected 0", multi_cnt); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; append_valid = 1'b0; append_data = '0;
    play_start = 1'b0; play_ready = 1'b0; check_start = 1'b0;
    guess_valid = 1'b0; guess_data = '0;
    test_reset();
    test_play();
    test_full();
    test_check();
    test_backpressure();
    test_clear();
    test_priority();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simon_seq_mem.md
Name: simon_seq_mem

Overview:
Parametrised sequence store for the Simon Says game. It replaces the fixed 2-bit, 10-entry read/write memory.
- Holds an append-only colour sequence with a length counter.
- Replays the sequence to the display path over a valid/ready stream.
- Checks player guesses against the stored sequence in order.
- Sits between the game controller (append/start commands) and the LED/button front-ends.

Parameters:
WIDTH, 2, bits per symbol (number of colours = 2^WIDTH)
DEPTH, 16, maximum sequence length in symbols
LEN_W, $clog2(DEPTH+1), width of the length and index counters (derived, not overridden)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
clear  input  1  empty the sequence and abort any operation
append_valid  input  1  append request
append_data  input  WIDTH  symbol to append
append_ready  output  1  append accepted this cycle when high together with append_valid
play_start  input  1  begin replay from index 0
play_valid  output  1  play_data valid
play_data  output  WIDTH  replayed symbol
play_last  output  1  high with the final replayed symbol
play_ready  input  1  consumer accepts the symbol
check_start  input  1  begin guess checking from index 0
guess_valid  input  1  player guess present
guess_data  input  WIDTH  guessed symbol
guess_ready  output  1  guess accepted this cycle when high together with guess_valid
check_match  output  1  one-cycle pulse: the accepted guess was correct, sequence not yet finished
check_fail  output  1  one-cycle pulse: the accepted guess was wrong; check ends
check_done  output  1  one-cycle pulse: the final guess was correct; check ends
seq_len  output  LEN_W  number of stored symbols
full  output  1  seq_len == DEPTH
empty  output  1  seq_len == 0
busy  output  1  state != IDLE

Behaviour:
Reset and clear
- Reset: state=IDLE, seq_len=0, index=0, all outputs 0 except empty=1.
- Memory array is not reset.
- clear (any state): next cycle state=IDLE, seq_len=0; the current operation is aborted with no result pulse.
- reset has priority over clear; clear has priority over every other input.

Memory
- Synchronous read, one-cycle latency. Single write port.
- Writes occur only in IDLE.

States
- IDLE:
  - append_ready = !full.
  - Append accepted: mem[seq_len] <= append_data, seq_len+1.
  - play_start && !empty: index=0, go PLAY_RD.
  - Otherwise check_start && !empty: index=0, go CHK_RD.
  - play_start takes priority over check_start. Both take priority over append in the same cycle; that append is dropped with append_ready=0.
  - Starts with empty=1 are ignored.
- PLAY_RD: issue read of mem[index]; go PLAY_OUT.
- PLAY_OUT:
  - play_valid=1; play_data is held stable until play_ready.
  - play_last = (index == seq_len-1).
  - On play_ready: if last, go IDLE; else index+1 and go PLAY_RD.
  - Replay throughput is at most one symbol per 2 cycles.
- CHK_RD: issue read of mem[index]; guess_ready=0; go CHK_WAIT.
- CHK_WAIT:
  - guess_ready=1.
  - On guess_valid, compare guess_data to the read data; the result pulses on the following cycle.
    - Mismatch: check_fail, go IDLE.
    - Match at the last index: check_done, go IDLE.
    - Otherwise: check_match, index+1, go CHK_RD.
- In CHK_RD, guesses are ignored (guess_ready=0); the front-end must hold or retry.

Boundaries
- append when full: ignored.
- DEPTH=1 works; seq_len never wraps.
- Result pulses are mutually exclusive.
- play_valid and guess_ready are never high together.

Optional Feature:
SIMON_SEQ_RAND_EN:
- Defined:
  - Internal 16-bit Galois LFSR (taps 0xB400, reset seed 0xACE1, never zero) advances every cycle.
  - On an accepted append, the stored symbol is LFSR[WIDTH-1:0] and append_data is ignored.
  - Extra output rand_sym (WIDTH) shows the value that would be stored this cycle.
- Undefined: no LFSR, no rand_sym port; append_data is stored.

Test Plan:
- Reset, then append 3,1,2 -> seq_len=3, empty=0, full=0; play_start with play_ready=1 -> play_data 3,1,2, play_last only on 2, busy drops after the last symbol.
- Append 16 symbols (DEPTH=16) -> full=1, append_ready=0; a 17th append -> seq_len stays 16.
- Stored 0,2: check_start, guesses 0,2 -> check_match, then check_done; stored 0,2 with guesses 0,3 -> check_match, then check_fail, back in IDLE.
- Replay with play_ready held low 5 cycles on symbol 1 -> play_data/play_valid stable throughout; advance on ready.
- clear mid-PLAY and mid-CHK_WAIT -> IDLE next cycle, seq_len=0, no check pulses; play_start on empty -> busy stays 0.
- play_start and check_start in the same cycle -> replay runs; append_valid in that cycle -> append_ready=0, seq_len unchanged.
